// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC fetch unit.
// Optional alignment checking in pc_fetch_unit is enabled with FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RETRY,
    S_VALID,
    S_HALT
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;
  localparam int RETRY_CNT_W = 8;
  localparam int ALIGN_BITS  = $clog2(INSTR_BYTES);

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Ack-timeout counter with terminal-count flag, plus the saturating retry counter.
module fetch_timeout_ctr
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   inc,
  input  logic                   retry_inc,
  output logic                   tc,
  output logic [RETRY_CNT_W-1:0] retry_count
);

  localparam logic [RETRY_CNT_W-1:0] TC_VALUE = RETRY_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_CNT_W-1:0] CNT_ONE  = RETRY_CNT_W'(1);
  localparam logic [RETRY_CNT_W-1:0] CNT_MAX  = '1;

  logic [RETRY_CNT_W-1:0] count;

  assign tc = (count == TC_VALUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_ONE;
    end
  end

  // Retry count sticks at its maximum rather than wrapping back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_count <= '0;
    end else if (retry_inc && (retry_count != CNT_MAX)) begin
      retry_count <= retry_count + CNT_ONE;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC holder and single-outstanding instruction fetcher.
// Define FETCH_ALIGN_CHECK_EN to halt on a misaligned NextPC and expose PCMisalign.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    PC_WIDTH       = 64,
  parameter int                    INSTR_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC       = '0,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                   CLK,
  input  logic                   Reset_L,
  input  logic [PC_WIDTH-1:0]    NextPC,
  output logic [PC_WIDTH-1:0]    CurrentPC,
  output logic                   IMemReq,
  output logic [PC_WIDTH-1:0]    IMemAddr,
  input  logic                   IMemAck,
  input  logic [INSTR_WIDTH-1:0] IMemData,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic                   InstrValid,
  input  logic                   InstrReady,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic                   PCMisalign,
`endif
  output logic [RETRY_CNT_W-1:0] FetchRetryCount
);

  fetch_state_t state;
  fetch_state_t next_state;

  logic load_instr;
  logic load_pc;
  logic ctr_clear;
  logic ctr_inc;
  logic retry_inc;
  logic ctr_tc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic set_misalign;
`endif

  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (CLK),
    .rst_n      (Reset_L),
    .clear      (ctr_clear),
    .inc        (ctr_inc),
    .retry_inc  (retry_inc),
    .tc         (ctr_tc),
    .retry_count(FetchRetryCount)
  );

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Ack wins over timeout, so an ack in the last allowed S_REQ cycle is still taken.
  always_comb begin
    next_state = state;
    load_instr = 1'b0;
    load_pc    = 1'b0;
    ctr_clear  = 1'b0;
    ctr_inc    = 1'b0;
    retry_inc  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    set_misalign = 1'b0;
`endif
    case (state)
      S_IDLE: next_state = S_REQ;
      S_REQ: begin
        if (IMemAck) begin
          load_instr = 1'b1;
          ctr_clear  = 1'b1;
          next_state = S_VALID;
        end else if (ctr_tc) begin
          ctr_clear  = 1'b1;
          retry_inc  = 1'b1;
          next_state = S_RETRY;
        end else begin
          ctr_inc = 1'b1;
        end
      end
      S_RETRY: next_state = S_REQ;
      S_VALID: begin
        if (InstrReady) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (NextPC[ALIGN_BITS-1:0] != '0) begin
            set_misalign = 1'b1;
            next_state   = S_HALT;
          end else begin
            load_pc    = 1'b1;
            next_state = S_REQ;
          end
`else
          load_pc    = 1'b1;
          next_state = S_REQ;
`endif
        end
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      CurrentPC <= RESET_PC;
    end else if (load_pc) begin
      CurrentPC <= NextPC;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      Instruction <= '0;
    end else if (load_instr) begin
      Instruction <= IMemData;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      PCMisalign <= 1'b0;
    end else if (set_misalign) begin
      PCMisalign <= 1'b1;
    end
  end
`endif

  assign IMemReq    = (state == S_REQ);
  assign InstrValid = (state == S_VALID);
  assign IMemAddr   = CurrentPC;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (FETCH_ALIGN_CHECK_EN aware).
module tb_pc_fetch_unit;

  localparam int PC_WIDTH    = 64;
  localparam int INSTR_WIDTH = 32;

  logic                   CLK;
  logic                   Reset_L;
  logic [PC_WIDTH-1:0]    NextPC;
  logic [PC_WIDTH-1:0]    CurrentPC;
  logic                   IMemReq;
  logic [PC_WIDTH-1:0]    IMemAddr;
  logic                   IMemAck;
  logic [INSTR_WIDTH-1:0] IMemData;
  logic [INSTR_WIDTH-1:0] Instruction;
  logic                   InstrValid;
  logic                   InstrReady;
  logic [7:0]             FetchRetryCount;
`ifdef FETCH_ALIGN_CHECK_EN
  logic                   PCMisalign;
`endif

  logic [PC_WIDTH-1:0] pcOffset;
  int checks;
  int errors;

  pc_fetch_unit #(
    .PC_WIDTH      (PC_WIDTH),
    .INSTR_WIDTH   (INSTR_WIDTH),
    .RESET_PC      (64'h0),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK            (CLK),
    .Reset_L        (Reset_L),
    .NextPC         (NextPC),
    .CurrentPC      (CurrentPC),
    .IMemReq        (IMemReq),
    .IMemAddr       (IMemAddr),
    .IMemAck        (IMemAck),
    .IMemData       (IMemData),
    .Instruction    (Instruction),
    .InstrValid     (InstrValid),
    .InstrReady     (InstrReady),
`ifdef FETCH_ALIGN_CHECK_EN
    .PCMisalign     (PCMisalign),
`endif
    .FetchRetryCount(FetchRetryCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stand-in for the downstream next-PC adder.
  always_comb NextPC = CurrentPC + pcOffset;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ack, input logic [INSTR_WIDTH-1:0] data,
                               input logic ready);
    IMemAck    = ack;
    IMemData   = data;
    InstrReady = ready;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    pcOffset = 64'd4;
    Reset_L  = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    #3;
    checkOutput("rst_req",   {63'd0, IMemReq},    64'd0);
    checkOutput("rst_valid", {63'd0, InstrValid}, 64'd0);
    checkOutput("rst_pc",    CurrentPC,           64'd0);
    checkOutput("rst_instr", {32'd0, Instruction}, 64'd0);
    checkOutput("rst_retry", {56'd0, FetchRetryCount}, 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    Reset_L = 1'b1;
    applyStimulus(1'b1, 32'hF8000001, 1'b1);
    checkOutput("idle_req", {63'd0, IMemReq}, 64'd0);

    // Back-to-back fetches: 0, 4, 8 every second cycle.
    step();
    checkOutput("f0_req",   {63'd0, IMemReq},    64'd1);
    checkOutput("f0_addr",  IMemAddr,            64'h0);
    checkOutput("f0_valid", {63'd0, InstrValid}, 64'd0);
    step();
    checkOutput("f0_ivalid", {63'd0, InstrValid}, 64'd1);
    checkOutput("f0_instr",  {32'd0, Instruction}, 64'hF8000001);
    checkOutput("f0_noreq",  {63'd0, IMemReq},    64'd0);
    step();
    checkOutput("f1_addr", IMemAddr, 64'h4);
    step();
    step();
    checkOutput("f2_addr", IMemAddr, 64'h8);
    applyStimulus(1'b1, 32'h00A00013, 1'b0);
    step();
    checkOutput("f2_valid", {63'd0, InstrValid}, 64'd1);
    checkOutput("f2_instr", {32'd0, Instruction}, 64'h00A00013);

    // Decode stall with a spurious ack in the middle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 2), 32'hDEADBEEF, 1'b0);
      step();
      checkOutput("stall_valid", {63'd0, InstrValid}, 64'd1);
      checkOutput("stall_req",   {63'd0, IMemReq},    64'd0);
      checkOutput("stall_pc",    CurrentPC,           64'h8);
      checkOutput("stall_instr", {32'd0, Instruction}, 64'h00A00013);
    end
    applyStimulus(1'b1, 32'h11111111, 1'b1);
    step();
    checkOutput("stall_accept", IMemAddr, 64'hC);
    step();
    step();
    checkOutput("pre_branch_addr", IMemAddr, 64'h10);
    step();
    pcOffset = 64'h40;
    step();
    checkOutput("branch_addr", IMemAddr, 64'h50);
    step();
    pcOffset = 64'd4;
    step();
    checkOutput("post_branch_addr", IMemAddr, 64'h54);

    // No ack for the full window: one retry, then a last-cycle ack is taken.
    applyStimulus(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step();
      checkOutput("wait_req", {63'd0, IMemReq}, 64'd1);
    end
    step();
    checkOutput("retry_req",   {63'd0, IMemReq},    64'd0);
    checkOutput("retry_valid", {63'd0, InstrValid}, 64'd0);
    checkOutput("retry_count", {56'd0, FetchRetryCount}, 64'd1);
    step();
    checkOutput("reissue_req",  {63'd0, IMemReq}, 64'd1);
    checkOutput("reissue_addr", IMemAddr,         64'h54);
    repeat (15) step();
    checkOutput("late_req",   {63'd0, IMemReq}, 64'd1);
    checkOutput("late_count", {56'd0, FetchRetryCount}, 64'd1);
    applyStimulus(1'b1, 32'h0BADF00D, 1'b0);
    step();
    checkOutput("late_valid", {63'd0, InstrValid}, 64'd1);
    checkOutput("late_instr", {32'd0, Instruction}, 64'h0BADF00D);
    checkOutput("late_count2", {56'd0, FetchRetryCount}, 64'd1);

    // Jump to 0x20, then reset in the middle of its S_REQ.
    pcOffset = 64'hFFFF_FFFF_FFFF_FFCC;
    applyStimulus(1'b0, 32'h0BADF00D, 1'b1);
    step();
    checkOutput("jump_addr", IMemAddr, 64'h20);
    applyStimulus(1'b1, 32'h22222222, 1'b0);
    #2;
    Reset_L = 1'b0;
    #1;
    checkOutput("mid_rst_req",   {63'd0, IMemReq},    64'd0);
    checkOutput("mid_rst_pc",    CurrentPC,           64'h0);
    checkOutput("mid_rst_instr", {32'd0, Instruction}, 64'h0);
    checkOutput("mid_rst_retry", {56'd0, FetchRetryCount}, 64'd0);
    step();
    checkOutput("held_rst_valid", {63'd0, InstrValid}, 64'd0);
    Reset_L  = 1'b1;
    pcOffset = 64'd4;
    checkOutput("rerel_idle", {63'd0, IMemReq}, 64'd0);
    step();
    checkOutput("rerel_req",  {63'd0, IMemReq}, 64'd1);
    checkOutput("rerel_addr", IMemAddr,         64'h0);
    step();
    checkOutput("rerel_instr", {32'd0, Instruction}, 64'h22222222);

    // Misaligned NextPC on accept.
    pcOffset = 64'h22;
    applyStimulus(1'b1, 32'h33333333, 1'b1);
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      checkOutput("halt_misalign", {63'd0, PCMisalign}, 64'd1);
      checkOutput("halt_req",      {63'd0, IMemReq},    64'd0);
      checkOutput("halt_valid",    {63'd0, InstrValid}, 64'd0);
      checkOutput("halt_pc",       CurrentPC,           64'h0);
      step();
    end
`else
    checkOutput("unchecked_pc",  CurrentPC,           64'h22);
    checkOutput("unchecked_req", {63'd0, IMemReq},    64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the architectural PC and fetches one 32-bit instruction per PC from instruction memory over a req/ack handshake.
- Presents the instruction and its PC to decode with a valid/ready handshake.
- Drives CurrentPC into the downstream next-PC logic and loads the NextPC it returns when decode accepts the instruction.
- Includes a bounded ack timeout with automatic retry and a saturating retry counter.

Parameters:
- PC_WIDTH, 64: width of PC, CurrentPC, NextPC and IMemAddr.
- INSTR_WIDTH, 32: width of IMemData and Instruction.
- RESET_PC, 64'h0: PC value loaded on reset.
- TIMEOUT_CYCLES, 16: number of consecutive S_REQ cycles without ack before a retry; legal range 2..255.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset_L  input  1  asynchronous active-low reset.
- NextPC  input  PC_WIDTH  next PC from the next-PC logic, combinationally derived from CurrentPC.
- CurrentPC  output  PC_WIDTH  registered PC of the instruction being fetched or held.
- IMemReq  output  1  fetch request.
- IMemAddr  output  PC_WIDTH  fetch address; equals CurrentPC.
- IMemAck  input  1  memory ack; IMemData is valid in the same cycle.
- IMemData  input  INSTR_WIDTH  fetched instruction.
- Instruction  output  INSTR_WIDTH  registered instruction to decode.
- InstrValid  output  1  Instruction/CurrentPC pair is valid.
- InstrReady  input  1  decode accepts the pair this cycle.
- FetchRetryCount  output  8  saturating count of timeout retries.
- PCMisalign  output  1  sticky misalignment flag; present only with FETCH_ALIGN_CHECK_EN.

Behaviour:
- Clock and reset: one clock, CLK. Reset_L is asynchronous and active-low.
- Reset values (Reset_L=0, asynchronous):
  - state=S_IDLE, CurrentPC=RESET_PC, Instruction=0.
  - Timeout counter=0, FetchRetryCount=0, PCMisalign=0.
  - IMemReq=0, InstrValid=0.
- Outputs decoded from registered state: IMemReq=(state==S_REQ); InstrValid=(state==S_VALID); IMemAddr=CurrentPC.
- S_IDLE: lasts exactly one cycle after reset release, then goes to S_REQ.
- S_REQ:
  - IMemAck=1 at the clock edge: Instruction<=IMemData, timeout counter<=0, go to S_VALID.
  - Else, if counter==TIMEOUT_CYCLES-1: counter<=0, FetchRetryCount increments and saturates at 255, go to S_RETRY.
  - Else: counter increments.
- S_RETRY: IMemReq=0 for exactly one cycle, then back to S_REQ with the same CurrentPC.
- S_VALID:
  - Instruction and CurrentPC are held stable while InstrReady=0; no bound on stall length.
  - InstrReady=1: CurrentPC<=NextPC, go to S_REQ.
- IMemAck outside S_REQ is ignored; no capture and no state change.
- Ack in the first S_REQ cycle is legal. Best-case throughput is 2 cycles per instruction: S_REQ then S_VALID.
- Memory latency: ack arriving in the Nth S_REQ cycle, where N≤TIMEOUT_CYCLES, is accepted.
- NextPC is sampled only on the S_VALID∧InstrReady edge, so combinational settling of the downstream next-PC logic is irrelevant at other times.
- PC arithmetic is owned by the downstream next-PC logic. This block never adds to the PC; wrap-around is whatever NextPC supplies.
- Reset asserted mid-operation: everything returns immediately to the reset values. An in-flight fetch is abandoned and a late ack is ignored because state is S_IDLE.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - On the S_VALID∧InstrReady edge with NextPC[1:0]!=0, PCMisalign<=1 and state goes to S_HALT; CurrentPC is not updated.
  - S_HALT: IMemReq=0, InstrValid=0; exited only by reset.
  - PCMisalign port exists.
- Undefined:
  - No check; NextPC is loaded unconditionally.
  - No S_HALT state and no PCMisalign port.

Decomposition:
- Shared package (fetch_pkg):
  - State enum fetch_state_t: S_IDLE, S_REQ, S_RETRY, S_VALID, S_HALT.
  - Constants INSTR_BYTES=4 and RETRY_CNT_W=8.
- One sub-module: fetch_timeout_ctr.
  - Clear/increment counter with terminal-count output plus the saturating retry counter.
  - The rest of the block (FSM and PC/instruction registers) stays in pc_fetch_unit.

Test Plan:
- Reset release, memory acks in first S_REQ cycle returning 32'hF8000001, InstrReady=1, NextPC=CurrentPC+4:
  - IMemReq high on cycle 2 after release, with IMemAddr=0.
  - InstrValid on cycle 3 with Instruction=32'hF8000001.
  - Addresses 0,4,8,… on every second cycle.
- InstrReady held 0 for 5 cycles in S_VALID: Instruction and CurrentPC stable, IMemReq=0 throughout; a spurious IMemAck pulse is ignored; PC loads NextPC on the accept edge.
- Branch: NextPC=CurrentPC+0x40 while CurrentPC=0x10: next IMemAddr=0x50, and the following fetch address comes from the new NextPC.
- No ack for 16 cycles:
  - S_RETRY entered with one IMemReq-low cycle; FetchRetryCount=1; same address reissued.
  - Ack on 16th cycle of the retry accepted without a second retry.
- Reset_L pulsed low mid-S_REQ at CurrentPC=0x20: outputs return to reset values asynchronously; next fetch after release is RESET_PC.
- With FETCH_ALIGN_CHECK_EN, NextPC=0x22 on accept: PCMisalign=1, IMemReq stays 0, CurrentPC unchanged until reset.
